// File: rtl/pci_bus_arbiter.sv
// Central PCI bus arbiter: round-robin req#/gnt# grant logic with
// FRAME#/IRDY# transaction tracking and unused-grant timeout.
module pci_bus_arbiter #(
  parameter  int NUM_MASTERS = 3,
  parameter  int GNT_TIMEOUT = 16,
  localparam int OWNER_W     = $clog2(NUM_MASTERS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_MASTERS-1:0] req_n,
  input  logic                   frame_n,
  input  logic                   irdy_n,
  output logic [NUM_MASTERS-1:0] gnt_n,
  output logic [OWNER_W-1:0]     owner,
  output logic                   bus_busy,
  output logic                   timeout
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_BUSY  = 2'd2;
  localparam logic [1:0] S_TURN  = 2'd3;

  localparam logic [7:0] CNT_LAST = 8'(GNT_TIMEOUT - 1);
  localparam logic [OWNER_W-1:0] OWNER_MAX = OWNER_W'(NUM_MASTERS - 1);

  logic [1:0]         state;
  logic [7:0]         cnt;
  logic               rr_valid;
  logic               any_req;
  logic [OWNER_W-1:0] winner;
  logic               frame_act;
  logic               irdy_act;
  logic               bus_idle;
  logic               own_req;
  logic [7:0]         cnt_inc;

  // undriven (z) lines read as deasserted thanks to the pull-ups
  assign frame_act = (frame_n == 1'b0);
  assign irdy_act  = (irdy_n == 1'b0);
  assign bus_idle  = !frame_act && !irdy_act;
  assign own_req   = (req_n[owner] == 1'b0);
  assign cnt_inc   = (cnt == 8'hFF) ? cnt : cnt + 8'd1;

  // search starts just past the last owner; straight from 0 after reset
  always_comb begin
    int start;
    int idx;
    any_req = 1'b0;
    winner  = '0;
    start   = 0;
    idx     = 0;
    if (rr_valid && owner != OWNER_MAX)
      start = int'(owner) + 1;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      idx = start + i;
      if (idx >= NUM_MASTERS)
        idx = idx - NUM_MASTERS;
      if (!any_req && req_n[OWNER_W'(idx)] == 1'b0) begin
        any_req = 1'b1;
        winner  = OWNER_W'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      gnt_n    <= '1;
      owner    <= '0;
      bus_busy <= 1'b0;
      timeout  <= 1'b0;
      cnt      <= '0;
      rr_valid <= 1'b0;
    end else begin
      timeout <= 1'b0;
      unique case (state)
        S_IDLE: begin
          gnt_n <= '1;
          if (frame_act) begin
            state    <= S_BUSY;
            bus_busy <= 1'b1;
          end else if (bus_idle && any_req) begin
            state    <= S_GRANT;
            owner    <= winner;
            gnt_n    <= ~(NUM_MASTERS'(1) << winner);
            cnt      <= '0;
            rr_valid <= 1'b1;
          end
        end
        S_GRANT: begin
          cnt <= cnt_inc;
          if (frame_act) begin
            state    <= S_BUSY;
            gnt_n    <= '1;
            bus_busy <= 1'b1;
          end else if (!own_req) begin
            state <= S_IDLE;
            gnt_n <= '1;
          end else if (cnt == CNT_LAST) begin
            state   <= S_IDLE;
            gnt_n   <= '1;
            timeout <= 1'b1;
          end
        end
        S_BUSY: begin
          gnt_n <= '1;
          if (bus_idle) begin
            state    <= S_TURN;
            bus_busy <= 1'b0;
          end
        end
        S_TURN: begin
          gnt_n <= '1;
          state <= S_IDLE;
        end
        default: begin
          state    <= S_IDLE;
          gnt_n    <= '1;
          bus_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pci_bus_arbiter.sv
// Directed bench for pci_bus_arbiter: vector table plus
// hand-written multi-cycle sequences (rotation, timeout, reset).
module tb_pci_bus_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] req_n;
  logic       frame_n;
  logic       irdy_n;
  logic [2:0] gnt_n;
  logic [1:0] owner;
  logic       bus_busy;
  logic       timeout;

  int n_checks = 0;
  int n_fail   = 0;

  pci_bus_arbiter #(
    .NUM_MASTERS(3),
    .GNT_TIMEOUT(16)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .req_n   (req_n),
    .frame_n (frame_n),
    .irdy_n  (irdy_n),
    .gnt_n   (gnt_n),
    .owner   (owner),
    .bus_busy(bus_busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [2:0] req;
    logic       frm;
    logic       irdy;
    logic [2:0] e_gnt;
    logic [1:0] e_own;
    logic       e_busy;
    logic       e_to;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    req_n   = 3'b111;
    frame_n = 1'b1;
    irdy_n  = 1'b1;
    step();
    reset = 1'b0;
  endtask

  // at most one grant low, checked every cycle
  always @(negedge clk) begin
    if (!reset)
      chk("gnt_onehot", 32'($countones(~gnt_n) <= 1), 32'd1);
  end

  task automatic wait_grant(input string name, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (gnt_n != 3'b111) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk(name, 32'(gnt_n), 32'h0);
  endtask

  initial begin
    logic       ok;
    int         held;
    logic       early_to;
    int         order[4];
    order = '{0, 1, 2, 0};

    //              rst req    frm  irdy gnt    own  busy to
    vq.push_back('{1, 3'b111, 1, 1, 3'b111, 2'd0, 0, 0});
    vq.push_back('{0, 3'b110, 1, 1, 3'b110, 2'd0, 0, 0});
    vq.push_back('{0, 3'b110, 0, 1, 3'b111, 2'd0, 1, 0});
    vq.push_back('{0, 3'b111, 0, 0, 3'b111, 2'd0, 1, 0});
    vq.push_back('{0, 3'b111, 1, 0, 3'b111, 2'd0, 1, 0});
    vq.push_back('{0, 3'b111, 1, 1, 3'b111, 2'd0, 0, 0});
    vq.push_back('{0, 3'b000, 1, 1, 3'b111, 2'd0, 0, 0});
    vq.push_back('{0, 3'b000, 1, 1, 3'b101, 2'd1, 0, 0});
    vq.push_back('{0, 3'b101, 1, 1, 3'b101, 2'd1, 0, 0});
    vq.push_back('{0, 3'b111, 1, 1, 3'b111, 2'd1, 0, 0});
    vq.push_back('{0, 3'b011, 1, 1, 3'b011, 2'd2, 0, 0});
    vq.push_back('{0, 3'b011, 1, 1, 3'b011, 2'd2, 0, 0});
    vq.push_back('{0, 3'b011, 1, 1, 3'b011, 2'd2, 0, 0});
    vq.push_back('{0, 3'b111, 1, 1, 3'b111, 2'd2, 0, 0});
    vq.push_back('{0, 3'b110, 1, 1, 3'b110, 2'd0, 0, 0});
    vq.push_back('{1, 3'b000, 1, 1, 3'b111, 2'd0, 0, 0});
    vq.push_back('{0, 3'b111, 0, 1, 3'b111, 2'd0, 1, 0});
    vq.push_back('{0, 3'b111, 1, 1, 3'b111, 2'd0, 0, 0});
    vq.push_back('{0, 3'b101, 1, 1, 3'b111, 2'd0, 0, 0});
    vq.push_back('{0, 3'b101, 1, 1, 3'b101, 2'd1, 0, 0});
    vq.push_back('{0, 3'b101, 1, 0, 3'b101, 2'd1, 0, 0});
    vq.push_back('{0, 3'b111, 1, 0, 3'b111, 2'd1, 0, 0});
    vq.push_back('{0, 3'b110, 1, 0, 3'b111, 2'd1, 0, 0});

    reset   = 1'b1;
    req_n   = 3'b111;
    frame_n = 1'b1;
    irdy_n  = 1'b1;
    step();

    foreach (vq[i]) begin
      reset   = vq[i].rst;
      req_n   = vq[i].req;
      frame_n = vq[i].frm;
      irdy_n  = vq[i].irdy;
      step();
      chk($sformatf("vec%0d_gnt", i), 32'(gnt_n), 32'(vq[i].e_gnt));
      chk($sformatf("vec%0d_owner", i), 32'(owner), 32'(vq[i].e_own));
      chk($sformatf("vec%0d_busy", i), 32'(bus_busy), 32'(vq[i].e_busy));
      chk($sformatf("vec%0d_to", i), 32'(timeout), 32'(vq[i].e_to));
    end

    // round-robin rotation with all masters requesting
    do_reset();
    req_n = 3'b000;
    for (int k = 0; k < 4; k++) begin
      wait_grant($sformatf("rr%0d_timeout", k), ok);
      if (!ok) break;
      chk($sformatf("rr%0d_gnt", k), 32'(gnt_n),
          32'(~(3'b001 << order[k]) & 3'b111));
      chk($sformatf("rr%0d_owner", k), 32'(owner), 32'(order[k]));
      frame_n = 1'b0;
      irdy_n  = 1'b1;
      step();
      chk($sformatf("rr%0d_busy", k), 32'(bus_busy), 32'd1);
      chk($sformatf("rr%0d_gnt_off", k), 32'(gnt_n), 32'h7);
      frame_n = 1'b1;
      irdy_n  = 1'b0;
      step();
      irdy_n = 1'b1;
    end

    // unused grant revoked after exactly 16 cycles
    do_reset();
    req_n = 3'b101;
    wait_grant("to_first_grant", ok);
    chk("to_gnt", 32'(gnt_n), 32'h5);
    held     = 1;
    early_to = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (gnt_n != 3'b101) break;
      held++;
      if (timeout) early_to = 1'b1;
    end
    chk("to_held", 32'(held), 32'd16);
    chk("to_early", 32'(early_to), 32'd0);
    chk("to_gnt_off", 32'(gnt_n), 32'h7);
    chk("to_pulse", 32'(timeout), 32'd1);
    step();
    chk("to_pulse_end", 32'(timeout), 32'd0);
    chk("to_regrant", 32'(gnt_n), 32'h5);

    // master 2 releases its request after three grant cycles
    do_reset();
    req_n = 3'b011;
    wait_grant("rel_grant", ok);
    chk("rel_gnt", 32'(gnt_n), 32'h3);
    step();
    step();
    req_n = 3'b111;
    step();
    chk("rel_gnt_off", 32'(gnt_n), 32'h7);
    chk("rel_to", 32'(timeout), 32'd0);
    chk("rel_owner", 32'(owner), 32'd2);

    // FRAME# on the last grant cycle beats the timeout
    do_reset();
    req_n = 3'b101;
    wait_grant("race_grant", ok);
    for (int i = 0; i < 15; i++) step();
    chk("race_pre_gnt", 32'(gnt_n), 32'h5);
    frame_n = 1'b0;
    step();
    chk("race_gnt", 32'(gnt_n), 32'h7);
    chk("race_busy", 32'(bus_busy), 32'd1);
    chk("race_to", 32'(timeout), 32'd0);

    // reset in the middle of a transaction
    req_n = 3'b000;
    step();
    chk("rst_pre_busy", 32'(bus_busy), 32'd1);
    reset = 1'b1;
    step();
    chk("rst_gnt", 32'(gnt_n), 32'h7);
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_busy", 32'(bus_busy), 32'd0);
    reset   = 1'b0;
    frame_n = 1'b1;
    step();
    chk("rst_first_gnt", 32'(gnt_n), 32'h6);
    chk("rst_first_owner", 32'(owner), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
